// File: rtl/dht11_reader.sv
// rtl/dht11_reader.sv - DHT11 single-wire reader: start pulse, response handshake, 40-bit frame capture, checksum check.
module dht11_reader #(
  parameter int CLK_FREQ_HZ   = 50000000,
  parameter int START_LOW_US  = 18000,
  parameter int TIMEOUT_US    = 200,
  parameter int BIT_THRESH_US = 40
) (
  input  logic       CLK,
  input  logic       RST,
  input  logic       START,
  input  logic       READ,
  output logic       DIR,
  output logic       SEND,
  output logic [7:0] HUM_INT,
  output logic [7:0] HUM_DEC,
  output logic [7:0] TEMP_INT,
  output logic [7:0] TEMP_DEC,
  output logic       BUSY,
  output logic       DONE,
  output logic       ERROR
);
  localparam int DIV  = CLK_FREQ_HZ / 1000000;
  localparam int PW   = $clog2(DIV + 1);
  localparam int TMAX = (START_LOW_US > TIMEOUT_US) ? START_LOW_US : TIMEOUT_US;
  localparam int TW   = $clog2(TMAX + 1);

  typedef enum logic [2:0] {
    IDLE, START_LOW, RELEASE, RESP_LOW, RESP_HIGH, BIT_LOW, BIT_HIGH, CHECK
  } state_t;

  state_t        state, state_next;
  logic [PW-1:0] presc;
  logic [TW-1:0] timer;
  logic          sync1, sync2, sync3;
  logic [39:0]   shreg;
  logic [5:0]    bit_cnt;
  logic [7:0]    sum;
  logic          tick, line_rise, line_fall, timeout;
  logic          shift_en, shift_bit, done_set, err_set;

  assign tick      = (presc == PW'(DIV - 1));
  assign line_rise = sync2 & ~sync3;
  assign line_fall = ~sync2 & sync3;
  assign timeout   = tick && (timer == TW'(TIMEOUT_US - 1));
  assign sum       = shreg[39:32] + shreg[31:24] + shreg[23:16] + shreg[15:8];

  assign DIR  = (state == START_LOW);
  assign SEND = ~DIR;
  assign BUSY = (state != IDLE);

  always_comb begin
    state_next = state;
    shift_en   = 1'b0;
    shift_bit  = 1'b0;
    done_set   = 1'b0;
    err_set    = 1'b0;
    case (state)
      IDLE:      if (START) state_next = START_LOW;
      START_LOW: if (tick && timer == TW'(START_LOW_US - 1)) state_next = RELEASE;
      RELEASE: begin
        if (timeout) begin err_set = 1'b1; state_next = IDLE; end
        else if (line_fall) state_next = RESP_LOW;
      end
      RESP_LOW: begin
        if (timeout) begin err_set = 1'b1; state_next = IDLE; end
        else if (line_rise) state_next = RESP_HIGH;
      end
      RESP_HIGH: begin
        if (timeout) begin err_set = 1'b1; state_next = IDLE; end
        else if (line_fall) state_next = BIT_LOW;
      end
      BIT_LOW: begin
        if (timeout) begin err_set = 1'b1; state_next = IDLE; end
        else if (line_rise) state_next = BIT_HIGH;
      end
      BIT_HIGH: begin
        if (timeout) begin err_set = 1'b1; state_next = IDLE; end
        else if (line_fall) begin
          // Bit value is the high-time length; the trailing release after bit 40 is not awaited.
          shift_en   = 1'b1;
          shift_bit  = (timer > TW'(BIT_THRESH_US));
          state_next = (bit_cnt == 6'd39) ? CHECK : BIT_LOW;
        end
      end
      CHECK: begin
        state_next = IDLE;
        if (sum == shreg[7:0]) done_set = 1'b1;
        else err_set = 1'b1;
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      state    <= IDLE;
      presc    <= '0;
      timer    <= '0;
      sync1    <= 1'b1;
      sync2    <= 1'b1;
      sync3    <= 1'b1;
      shreg    <= '0;
      bit_cnt  <= '0;
      DONE     <= 1'b0;
      ERROR    <= 1'b0;
      HUM_INT  <= '0;
      HUM_DEC  <= '0;
      TEMP_INT <= '0;
      TEMP_DEC <= '0;
    end else begin
      state <= state_next;
      sync1 <= READ;
      sync2 <= sync1;
      sync3 <= sync2;
      // Prescaler restarts with each phase so phase lengths are whole ticks.
      if (state_next != state || tick) presc <= '0;
      else presc <= presc + 1'b1;
      if (state_next != state || state == IDLE) timer <= '0;
      else if (tick) timer <= timer + 1'b1;
      if (shift_en) shreg <= {shreg[38:0], shift_bit};
      if (state == RESP_HIGH) bit_cnt <= '0;
      else if (shift_en) bit_cnt <= bit_cnt + 6'd1;
      DONE  <= done_set;
      ERROR <= err_set;
      if (done_set) begin
        HUM_INT  <= shreg[39:32];
        HUM_DEC  <= shreg[31:24];
        TEMP_INT <= shreg[23:16];
        TEMP_DEC <= shreg[15:8];
      end
    end
  end
endmodule

// File: doc/dht11_reader.md
DHT11_READER -- requirements
Module: dht11_reader

Interface
REQ-001 Parameter CLK_FREQ_HZ, default 50000000, system clock frequency in Hz; SHALL be an integer multiple of 1000000.
REQ-002 Parameter START_LOW_US, default 18000, host start pulse length in microseconds.
REQ-003 Parameter TIMEOUT_US, default 200, maximum duration of any single sensor phase in microseconds.
REQ-004 Parameter BIT_THRESH_US, default 40, high-time above which a data bit is decoded as 1.
REQ-005 CLK  input  1  single system clock; all logic on its rising edge.
REQ-006 RST  input  1  reset, synchronous and active-high.
REQ-007 START  input  1  one-cycle request to begin a measurement.
REQ-008 READ  input  1  sampled level of the DHT11 data line, from the tri-state buffer.
REQ-009 DIR  output  1  tri-state direction; 1 = this block drives the line, 0 = line released.
REQ-010 SEND  output  1  level driven onto the line when DIR=1.
REQ-011 HUM_INT, HUM_DEC, TEMP_INT, TEMP_DEC  output  8 each  last valid measurement bytes 1..4.
REQ-012 BUSY  output  1  high from acceptance of START until DONE or ERROR.
REQ-013 DONE  output  1  one-cycle pulse: new valid data on the measurement outputs.
REQ-014 ERROR  output  1  one-cycle pulse: transaction aborted by timeout or bad checksum.

Function
REQ-015 READ SHALL pass through a 2-flop synchronizer; all decoding uses the synchronized value and its edges (2-cycle latency).
REQ-016 A 1 us tick SHALL be generated by a prescaler counting CLK_FREQ_HZ/1000000 cycles; all phase timers count ticks and clear on every state transition.
REQ-017 States: IDLE, START_LOW, RELEASE, RESP_LOW, RESP_HIGH, BIT_LOW, BIT_HIGH, CHECK.
REQ-018 IDLE: DIR=0, SEND=1, BUSY=0; START=1 moves to START_LOW the next cycle and sets BUSY=1.
REQ-019 START_LOW: DIR=1, SEND=0 for START_LOW_US ticks, then RELEASE.
REQ-020 RELEASE: DIR=0; wait for a falling edge of synchronized READ, then RESP_LOW.
REQ-021 RESP_LOW: wait for rising edge, then RESP_HIGH; RESP_HIGH: wait for falling edge, then BIT_LOW with bit counter 0.
REQ-022 BIT_LOW: wait for rising edge, then BIT_HIGH; BIT_HIGH: on falling edge, shift 1 into a 40-bit register, MSB first, if elapsed ticks > BIT_THRESH_US, else shift 0.
REQ-023 After the 40th bit the FSM SHALL enter CHECK without waiting for the sensor's trailing release.
REQ-024 CHECK: if (byte1+byte2+byte3+byte4) mod 256 equals byte5, load the four outputs and pulse DONE; otherwise pulse ERROR and leave outputs unchanged; both paths return to IDLE with BUSY=0 in the same cycle as the pulse.
REQ-025 In RELEASE, RESP_LOW, RESP_HIGH, BIT_LOW or BIT_HIGH, a timer reaching TIMEOUT_US SHALL pulse ERROR and return to IDLE with DIR=0.
REQ-026 START while BUSY=1 SHALL be ignored; DONE and ERROR SHALL never assert in the same cycle.
REQ-027 DIR SHALL be 1 only in START_LOW; SEND SHALL be 0 whenever DIR=1.

Reset
REQ-028 RST=1 SHALL force, on the next rising edge: state IDLE, DIR=0, SEND=1, BUSY=0, DONE=0, ERROR=0, measurement outputs 0x00, shift register, bit counter, timers and prescaler 0.
REQ-029 RST asserted mid-transaction SHALL abort without a DONE or ERROR pulse and release the line (DIR=0) on that edge.

Verification (START_LOW_US=20 and a sensor model with the standard 80/80 us response and 50 us low / 26 or 70 us high bits)
REQ-030 Frame 0x37 0x00 0x19 0x00 0x50 -> DONE one cycle, HUM_INT=55, HUM_DEC=0, TEMP_INT=25, TEMP_DEC=0, ERROR=0, BUSY low afterwards.
REQ-031 Same frame with checksum 0x51 -> ERROR one cycle, no DONE, outputs keep previous values.
REQ-032 No sensor response after start -> DIR=1 for exactly 20 ticks, then ERROR after 200 ticks in RELEASE.
REQ-033 Sensor stalls high during bit 17 -> ERROR after 200 ticks in BIT_HIGH; a following START with a good frame yields DONE.
REQ-034 RST pulsed during bit 10 -> DIR=0, BUSY=0, outputs 0x00, no DONE/ERROR; the next START succeeds.
REQ-035 START pulsed while BUSY=1 -> ignored; exactly one DONE for the transaction.
